// File: rtl/instr_fetch_unit.sv
// BRISC fetch/pre-decode: assembles 3-byte instructions from byte-wide
// program memory (one byte per handshake), holds them for execute and
// produces the operand-B select code. Branch redirects abort any fetch.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [3:0] LINK_OPC_HI = 4'hE
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] opcode,
  output logic [3:0] rd,
  output logic [3:0] rs,
  output logic [7:0] immediate,
  output logic [1:0] imm_ctl,
  output logic [7:0] instr_pc
);

  typedef enum logic [2:0] {
    S_START, S_F0, S_F1, S_F2, S_HOLD, S_DRAIN
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_fetch_pc, w_pc_nxt;
  logic       w_take;
  logic       r_instr_valid;
  logic [7:0] r_opcode, r_imm, r_instr_pc;
  logic [3:0] r_rd, r_rs;
  logic [1:0] r_imm_ctl;

  // Operand-B select: link opcodes take PC+3, other high opcodes take the immediate.
  function automatic logic [1:0] f_imm_ctl(input logic [7:0] op);
    if (op[7:4] == LINK_OPC_HI) return 2'd2;
    else if (op[7])             return 2'd1;
    else                        return 2'd0;
  endfunction

  // Next-state / next fetch address; redirect overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_fetch_pc;
    w_take      = 1'b0;
    if (redirect) begin
      w_pc_nxt = redirect_pc;
      case (r_state)
        // A request is in flight unless its ack lands this very cycle.
        S_F0, S_F1, S_F2: w_state_nxt = mem_ack ? S_F0 : S_DRAIN;
        // The abandoned request completing frees us to restart.
        S_DRAIN:          w_state_nxt = mem_ack ? S_F0 : S_DRAIN;
        default:          w_state_nxt = S_F0;
      endcase
    end else begin
      case (r_state)
        S_START: w_state_nxt = S_F0;
        S_F0, S_F1, S_F2: begin
          if (mem_ack) begin
            w_take      = 1'b1;
            w_pc_nxt    = r_fetch_pc + 8'd1;
            w_state_nxt = (r_state == S_F0) ? S_F1 :
                          (r_state == S_F1) ? S_F2 : S_HOLD;
          end
        end
        S_HOLD:  if (instr_ready) w_state_nxt = S_F0;
        S_DRAIN: if (mem_ack)     w_state_nxt = S_F0;
        default: w_state_nxt = S_START;
      endcase
    end
  end

  // State and fetch-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_START;
      r_fetch_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_pc_nxt;
      r_instr_valid <= (w_state_nxt == S_HOLD);
    end
  end

  // Instruction byte capture with registered pre-decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode   <= '0;
      r_imm_ctl  <= '0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_imm      <= '0;
      r_instr_pc <= '0;
    end else begin
      // Byte 0 address is whatever fetch_pc will be when F0 starts.
      if (w_state_nxt == S_F0) r_instr_pc <= w_pc_nxt;
      if (w_take) begin
        case (r_state)
          S_F0: begin
            r_opcode  <= mem_rdata;
            r_imm_ctl <= f_imm_ctl(mem_rdata);
          end
          S_F1:    {r_rd, r_rs} <= mem_rdata;
          S_F2:    r_imm <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  assign mem_req     = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_F2);
  assign mem_addr    = r_fetch_pc;
  assign instr_valid = r_instr_valid;
  assign opcode      = r_opcode;
  assign rd          = r_rd;
  assign rs          = r_rs;
  assign immediate   = r_imm;
  assign imm_ctl     = r_imm_ctl;
  assign instr_pc    = r_instr_pc;

endmodule
